// File: rtl/apb_master.sv
// APB requester: one SETUP/ACCESS transfer per accepted command, with a
// registered valid/ready response and a wait-state timeout.
module apb_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // A zero timeout still needs a legal (1-bit) counter width.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: the bench acts as APB slave and response consumer,
// and compares each transfer against a transfer-level model of the protocol.
module tb_apb_master;

  localparam int TO = 16;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int total = 0;
  int bad   = 0;

  // observations of the most recent transfer
  int          o_psel, o_pen, o_lat;
  logic        o_hung, o_stable, o_block, o_after_valid, o_after_ready;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic        o_write, o_err, o_to;

  apb_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Transfer-level model: slave answers after `waits` wait states unless the
  // master gives up after TO enable cycles.
  function automatic int exp_pen(input int waits);
    return (waits < TO) ? waits + 1 : TO;
  endfunction

  function automatic logic exp_to(input int waits);
    return (waits >= TO);
  endfunction

  // Drives one command (DUT assumed idle) and records what it observed.
  task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int waits, input logic [31:0] rd, input logic se,
                          input int hold, input logic pend, input logic [31:0] pa);
    int   acc;
    logic got;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b0;
    o_psel = 0; o_pen = 0; o_lat = 0; o_hung = 1'b0; o_stable = 1'b1; o_block = 1'b0;
    o_addr = '0; o_wdata = '0; o_write = 1'b0; acc = 0; got = 1'b0;
    o_after_valid = 1'b1; o_after_ready = 1'b0;
    while (!got) begin
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      o_lat++;
      if (PSEL === 1'b1) o_psel++;
      if (PENABLE === 1'b1) o_pen++;
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        if (acc == 0) begin o_addr = PADDR; o_wdata = PWDATA; o_write = PWRITE; end
        if (acc == waits) begin PREADY = 1'b1; PSLVERR = se; PRDATA = rd; end
        else begin PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom; end
        acc++;
      end else begin
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
      if (rsp_valid === 1'b1) got = 1'b1;
      if (o_lat > 100) begin o_hung = 1'b1; got = 1'b1; end
    end
    if (!o_hung) begin
      o_rdata = rsp_rdata; o_err = rsp_err; o_to = rsp_timeout;
      if (cmd_ready !== 1'b0 || PSEL !== 1'b0) o_block = 1'b1;
      if (pend) begin
        cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = pa; cmd_wdata = $urandom;
      end
      for (int i = 0; i < hold; i++) begin
        @(posedge PCLK); #1;
        if (rsp_valid !== 1'b1 || rsp_rdata !== o_rdata || rsp_err !== o_err ||
            rsp_timeout !== o_to) o_stable = 1'b0;
        if (cmd_ready !== 1'b0 || PSEL !== 1'b0) o_block = 1'b1;
      end
      rsp_ready = 1'b1;
      @(posedge PCLK); #1;
      o_after_valid = rsp_valid; o_after_ready = cmd_ready;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(posedge PCLK);
    #2 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin bad++; $display("FAIL reset_apb_ctrl got=%b exp=000", {PSEL, PENABLE, PWRITE}); end
    total++; if (PADDR !== 32'h0) begin bad++; $display("FAIL reset_paddr got=%h exp=0", PADDR); end
    total++; if (PWDATA !== 32'h0) begin bad++; $display("FAIL reset_pwdata got=%h exp=0", PWDATA); end
    total++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000) begin bad++; $display("FAIL reset_rsp_flags got=%b exp=000", {rsp_valid, rsp_err, rsp_timeout}); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write;
    run_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h1234_5678, 1'b0, 0, 1'b0, 32'h0);
    total++; if (o_hung !== 1'b0) begin bad++; $display("FAIL write_hung got=%b exp=0", o_hung); end
    total++; if (o_psel != 2) begin bad++; $display("FAIL write_psel_cycles got=%0d exp=2", o_psel); end
    total++; if (o_pen != 1) begin bad++; $display("FAIL write_penable_cycles got=%0d exp=1", o_pen); end
    total++; if (o_lat != 3) begin bad++; $display("FAIL write_latency got=%0d exp=3", o_lat); end
    total++; if ({o_addr, o_wdata, o_write} !== {32'h10, 32'hDEADBEEF, 1'b1}) begin bad++; $display("FAIL write_apb_fields got=%h/%h/%b exp=10/deadbeef/1", o_addr, o_wdata, o_write); end
    total++; if ({o_err, o_to} !== 2'b00) begin bad++; $display("FAIL write_rsp_err got=%b exp=00", {o_err, o_to}); end
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL write_rsp_rdata got=%h exp=0", o_rdata); end
    total++; if ({o_after_valid, o_after_ready} !== 2'b01) begin bad++; $display("FAIL write_handshake got=%b exp=01", {o_after_valid, o_after_ready}); end
    total++; if ({PADDR, PWDATA, PWRITE, PSEL} !== {32'h10, 32'hDEADBEEF, 1'b1, 1'b0}) begin bad++; $display("FAIL write_hold_fields got=%h/%h/%b/%b", PADDR, PWDATA, PWRITE, PSEL); end
  endtask

  task automatic test_read_wait;
    run_xfer(1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, 1'b0, 32'h0);
    total++; if (o_pen != 4) begin bad++; $display("FAIL rdwait_access_cycles got=%0d exp=4", o_pen); end
    total++; if (o_lat != 6) begin bad++; $display("FAIL rdwait_latency got=%0d exp=6", o_lat); end
    total++; if (o_write !== 1'b0) begin bad++; $display("FAIL rdwait_pwrite got=%b exp=0", o_write); end
    total++; if (o_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rdwait_rdata got=%h exp=deadbeef", o_rdata); end
    total++; if ({o_err, o_to} !== 2'b00) begin bad++; $display("FAIL rdwait_err got=%b exp=00", {o_err, o_to}); end
  endtask

  task automatic test_slverr;
    logic [31:0] rd;
    rd = $urandom;
    run_xfer(1'b0, 32'h400, 32'h0, 0, rd, 1'b1, 0, 1'b0, 32'h0);
    total++; if (o_addr !== 32'h400) begin bad++; $display("FAIL slverr_paddr got=%h exp=400", o_addr); end
    total++; if ({o_err, o_to} !== 2'b10) begin bad++; $display("FAIL slverr_flags got=%b exp=10", {o_err, o_to}); end
    total++; if (o_rdata !== rd) begin bad++; $display("FAIL slverr_rdata got=%h exp=%h", o_rdata, rd); end
  endtask

  task automatic test_timeout;
    run_xfer(1'b0, 32'h44, 32'h0, 1000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 32'h0);
    total++; if (o_hung !== 1'b0) begin bad++; $display("FAIL timeout_hung got=%b exp=0", o_hung); end
    total++; if (o_pen != TO) begin bad++; $display("FAIL timeout_penable_cycles got=%0d exp=%0d", o_pen, TO); end
    total++; if (o_psel != TO + 1) begin bad++; $display("FAIL timeout_psel_cycles got=%0d exp=%0d", o_psel, TO + 1); end
    total++; if ({o_err, o_to} !== 2'b11) begin bad++; $display("FAIL timeout_flags got=%b exp=11", {o_err, o_to}); end
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL timeout_rdata got=%h exp=0", o_rdata); end
    run_xfer(1'b1, 32'h48, 32'hA5A5_5A5A, TO - 1, 32'h0, 1'b0, 0, 1'b0, 32'h0);
    total++; if ({o_pen, 30'b0, o_to} !== {TO, 30'b0, 1'b0}) begin bad++; $display("FAIL timeout_edge got=pen%0d/to%b exp=pen%0d/to0", o_pen, o_to, TO); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a2;
    a2 = 32'hCAFE_0000 | 32'($urandom_range(0, 255));
    run_xfer(1'b0, 32'h80, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 5, 1'b1, a2);
    total++; if (o_stable !== 1'b1) begin bad++; $display("FAIL b2b_rsp_stable got=%b exp=1", o_stable); end
    total++; if (o_block !== 1'b0) begin bad++; $display("FAIL b2b_blocked got=%b exp=0", o_block); end
    total++; if (o_rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL b2b_rdata got=%h exp=0badf00d", o_rdata); end
    total++; if ({o_after_valid, o_after_ready} !== 2'b01) begin bad++; $display("FAIL b2b_release got=%b exp=01", {o_after_valid, o_after_ready}); end
    run_xfer(1'b1, a2, 32'h600D_600D, 0, 32'h0, 1'b0, 0, 1'b0, 32'h0);
    total++; if (o_lat != 3 || o_addr !== a2) begin bad++; $display("FAIL b2b_second got=lat%0d/%h exp=lat3/%h", o_lat, o_addr, a2); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; rsp_ready = 1'b1; PREADY = 1'b0;
    @(posedge PCLK); #1 cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    total++; if ({PSEL, PENABLE} !== 2'b11) begin bad++; $display("FAIL rstmid_in_access got=%b exp=11", {PSEL, PENABLE}); end
    @(posedge PCLK); #2 PRESETn = 1'b0; #1;
    total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin bad++; $display("FAIL rstmid_async_drop got=%b exp=000", {PSEL, PENABLE, rsp_valid}); end
    PREADY = 1'b1; PSLVERR = 1'b0;
    @(posedge PCLK); #2 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_cmd_ready got=%b exp=1", cmd_ready); end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK); #1;
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_response got=%b exp=0", seen); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_random;
    logic        w, se;
    logic [31:0] a, d, rd, er;
    int          waits, hold;
    for (int n = 0; n < 25; n++) begin
      w = 1'($urandom); se = 1'($urandom); a = $urandom; d = $urandom; rd = $urandom;
      waits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO - 1, TO + 4)) : int'($urandom_range(0, 6));
      hold  = int'($urandom_range(0, 3));
      run_xfer(w, a, d, waits, rd, se, hold, 1'b0, 32'h0);
      er = (exp_to(waits) || w) ? 32'h0 : rd;
      total++; if (o_pen != exp_pen(waits) || o_lat != exp_pen(waits) + 2) begin bad++; $display("FAIL rnd%0d_timing got=pen%0d/lat%0d exp=pen%0d", n, o_pen, o_lat, exp_pen(waits)); end
      total++; if ({o_addr, o_wdata, o_write} !== {a, d, w}) begin bad++; $display("FAIL rnd%0d_apb got=%h/%h/%b exp=%h/%h/%b", n, o_addr, o_wdata, o_write, a, d, w); end
      total++; if (o_rdata !== er) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", n, o_rdata, er); end
      total++; if ({o_err, o_to} !== {exp_to(waits) | se, exp_to(waits)}) begin bad++; $display("FAIL rnd%0d_flags got=%b exp=%b", n, {o_err, o_to}, {exp_to(waits) | se, exp_to(waits)}); end
      total++; if ({o_stable, o_block, o_after_valid, o_after_ready} !== 4'b1001) begin bad++; $display("FAIL rnd%0d_handshake got=%b exp=1001", n, {o_stable, o_block, o_after_valid, o_after_ready}); end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_wait;
    test_slverr;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
